// File: rtl/ping_pong_counter_param.sv
// ping_pong_counter_param
//
// General-purpose pattern counter with runtime-programmable bounds and step.
// It supports four counting modes:
//   0 ping-pong  : bounces between lo and hi, and can be reversed by flip.
//   1 wrap-up    : counts up, then returns from hi to lo.
//   2 wrap-down  : counts down, then returns from lo to hi.
//   3 one-shot   : counts up to hi, then holds with done set until load or rst.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   enable    in   advance one step this cycle
//   mode      in   [1:0] counting mode (see above)
//   lo, hi    in   [WIDTH-1:0] inclusive bounds
//   step      in   [WIDTH-1:0] increment magnitude
//   load      in   synchronous load of load_val (beats enable and cfg_err)
//   load_val  in   [WIDTH-1:0] value written on load (not range-checked)
//   flip      in   ping-pong only: reverse direction on this enabled step
//   out       out  [WIDTH-1:0] registered count
//   direction out  1 = last move up, 0 = last move down
//   turn      out  one-cycle pulse on the cycle out changes due to reversal/wrap
//   done      out  sticky one-shot completion flag
//   cfg_err   out  combinational, lo > hi
//
// Per-cycle priority: rst > load > cfg_err hold > enable > hold.
// This block has no handshake: every input is sampled on each rising edge.
// The counter has no FSM. Its full state is visible on out/direction/turn/done.

module ping_pong_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             flip,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             turn,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [1:0] MODE_PING_PONG = 2'd0;
    localparam logic [1:0] MODE_WRAP_UP   = 2'd1;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'd2;

    logic [WIDTH-1:0] out_q, out_d;
    logic             direction_q, direction_d;
    logic             turn_q, turn_d;
    logic             done_q, done_d;

    // Saturating neighbours of out_q. Both are computed one bit wider than
    // the counter, so an overflow past the top of the range or an underflow
    // below zero shows up in the extra bit instead of wrapping silently.
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] down_val;
    logic             pp_dir;

    assign cfg_err = (lo > hi);

    always_comb begin
        sum_w  = {1'b0, out_q} + {1'b0, step};
        diff_w = {1'b0, out_q} - {1'b0, step};

        up_val = sum_w[WIDTH-1:0];
        if (sum_w > {1'b0, hi}) begin
            up_val = hi;
        end

        // diff_w[WIDTH] set means out_q - step went below zero.
        down_val = diff_w[WIDTH-1:0];
        if (diff_w[WIDTH] || (diff_w[WIDTH-1:0] < lo)) begin
            down_val = lo;
        end

        // The bounds override flip: at hi the count must go down,
        // and at lo it must go up.
        if (out_q == hi) begin
            pp_dir = 1'b0;
        end else if (out_q == lo) begin
            pp_dir = 1'b1;
        end else begin
            pp_dir = direction_q ^ flip;
        end
    end

    always_comb begin
        out_d       = out_q;
        direction_d = direction_q;
        turn_d      = 1'b0;
        done_d      = done_q;

        if (load) begin
            out_d       = load_val;
            direction_d = 1'b1;
            done_d      = 1'b0;
        end else if (cfg_err) begin
            // Inconsistent bounds: freeze until software fixes them.
        end else if (enable) begin
            if (out_q < lo) begin
                // Out of range (e.g. after a bound change or a raw load):
                // snap to the nearest bound first, then count from there.
                out_d       = lo;
                direction_d = 1'b1;
            end else if (out_q > hi) begin
                out_d       = hi;
                direction_d = 1'b0;
            end else if (step == '0) begin
                // Zero stride: nothing moves, not even done.
            end else begin
                case (mode)
                    MODE_PING_PONG: begin
                        if (lo != hi) begin
                            out_d       = pp_dir ? up_val : down_val;
                            direction_d = pp_dir;
                            turn_d      = (pp_dir != direction_q);
                        end
                    end
                    MODE_WRAP_UP: begin
                        direction_d = 1'b1;
                        if (out_q == hi) begin
                            out_d  = lo;
                            turn_d = 1'b1;
                        end else begin
                            out_d = up_val;
                        end
                    end
                    MODE_WRAP_DOWN: begin
                        direction_d = 1'b0;
                        if (out_q == lo) begin
                            out_d  = hi;
                            turn_d = 1'b1;
                        end else begin
                            out_d = down_val;
                        end
                    end
                    default: begin
                        // One-shot. up_val is clamped to hi, so this one test
                        // covers both cases: reaching hi on this step, and
                        // already sitting at hi when enabled.
                        if (!done_q) begin
                            out_d       = up_val;
                            direction_d = 1'b1;
                            done_d      = (up_val == hi);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            direction_q <= 1'b1;
            turn_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            direction_q <= direction_d;
            turn_q      <= turn_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign direction = direction_q;
    assign turn      = turn_q;
    assign done      = done_q;

endmodule

// File: doc/ping_pong_counter_param.md
Name: ping_pong_counter_param

Overview:
- Parametrised successor to the fixed 4-bit ping-pong counter.
- Adds runtime-programmable lower/upper bounds and step size.
- Adds four counting modes: ping-pong, wrap-up, wrap-down and one-shot up.
- Adds synchronous load, an external direction flip, a turnaround pulse, a one-shot done flag and bound-configuration error detection.
- Sits in the lab datapath as the general-purpose pattern counter that feeds display and sequencing logic.

Parameters:
- WIDTH, 4, counter/bound/step width in bits (≥2).

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance the counter one step this cycle
- mode  in  2  0 = ping-pong, 1 = wrap-up, 2 = wrap-down, 3 = one-shot up
- lo  in  WIDTH  lower bound, inclusive
- hi  in  WIDTH  upper bound, inclusive
- step  in  WIDTH  increment magnitude per enabled cycle
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value written on load
- flip  in  1  ping-pong only: reverse direction on this enabled step
- out  out  WIDTH  registered count
- direction  out  1  registered; 1 = last move up, 0 = last move down
- turn  out  1  registered 1-cycle pulse, set on the cycle out changes due to a reversal or wrap
- done  out  1  registered, sticky; one-shot reached hi
- cfg_err  out  1  combinational; high when lo > hi

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: out = 0, direction = 1, turn = 0, done = 0.
- Priority per cycle: rst > load > cfg_err hold > enable > hold.
- Load:
  - out <= load_val; direction <= 1; done <= 0; turn <= 0.
  - load_val is not range-checked.
- cfg_err = (lo > hi). While high with no load, all registers hold and turn <= 0.
- Enable low: all registers hold; turn <= 0.
- Out-of-range, enabled, any mode:
  - out < lo → out <= lo, direction <= 1.
  - out > hi → out <= hi, direction <= 0.
  - turn <= 0.
- step == 0, enabled, in range: out and direction hold; turn <= 0.
- Arithmetic:
  - Sums are computed in WIDTH+1 bits.
  - up = min(out + step, hi); down = max(out − step, lo), with underflow detected via the extra bit.
  - Results never leave [lo, hi].
- Mode 0, ping-pong:
  - Effective direction d = 0 if out == hi; d = 1 if out == lo; otherwise direction XOR flip.
  - If lo == hi: out holds, direction holds.
  - Otherwise out <= (d ? up : down), direction <= d, turn <= (d != direction).
- Mode 1, wrap-up:
  - out == hi → out <= lo, turn <= 1.
  - Otherwise out <= up, turn <= 0.
  - direction <= 1.
- Mode 2, wrap-down:
  - out == lo → out <= hi, turn <= 1.
  - Otherwise out <= down, turn <= 0.
  - direction <= 0.
- Mode 3, one-shot:
  - done == 1 → hold.
  - Otherwise out <= up, direction <= 1.
  - done <= 1 on the cycle out becomes hi, or immediately if out == hi when enabled.
  - turn <= 0.
- Mode change mid-count takes effect on the next enabled cycle with no flush.
- done clears only on rst or load.
- Bound changes apply on the next cycle via the out-of-range rule.
- flip is ignored outside mode 0 and is overridden at either bound.

Test Plan (WIDTH = 4):
- Ping-pong full range: rst 2 cycles; lo=0, hi=15, step=1, mode=0, enable=1 → out 0,1,…,15,14,…,0,1.
  - direction = 0 from the cycle out = 14.
  - turn = 1 exactly when out becomes 14 and when out becomes 1 (the upturn).
- Clamped stride: load 3; lo=3, hi=10, step=3, mode=0 → out 3,6,9,10,7,4,3,6.
  - turn on 7 and on 6.
- Wrap-up: lo=2, hi=5, step=2, mode=1, load 2 → out 2,4,5,2,4; turn on each return to 2.
  - Repeat with mode=2 from 5 → 5,3,2,5.
- One-shot: lo=0, hi=4, step=1, mode=3, load 0 → 0,1,2,3,4; done = 1 at 4 and stays 4 for 5 more enabled cycles.
  - load 1 → done = 0, counting resumes.
- Config error and out-of-range: out = 7, set lo=9, hi=4 → cfg_err = 1, out holds 7.
  - Set hi=12 → next enabled cycle out = 9, direction = 1.
- Flip and mid-operation reset: mode=0, out=7, direction=1, flip=1 → out=6, direction=0, turn=1.
  - Assert rst with enable high → next cycle out=0, direction=1, done=0, turn=0.
